icache_dm16: RTL and testbench

Direct-mapped, read-only instruction cache with 16 lines of 32 bytes (256 bits) and a 6-bit physical tag. It sits in the fetch stage. It answers a lookup combinationally with line data plus hit/miss, presents the line-aligned miss address to the memory side, and installs a returned line when the fill is acknowledged. Valid state is held in 16 flip-flops: a 1-to-16 decoder selects the one to set, and a 16-to-1 selector reads it back.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_valid_bits.sv | 52 +++++
 rtl/icache_dm16.sv | 72 +++++++
 tb/tb_icache_dm16.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ============================================================================
// icache_pkg : shared widths and types for the icache_dm16 instruction cache
// Rev 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int TAG_W     = 6;
  localparam int INDEX_W   = 4;
  localparam int LINE_W    = 256;
  localparam int OFFSET_W  = 5;
  localparam int ADDR_W    = TAG_W + INDEX_W + OFFSET_W;
  localparam int NUM_LINES = 1 << INDEX_W;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [LINE_W-1:0]  line_t;

endpackage

`default_nettype wire

// File: rtl/icache_valid_bits.sv
// ============================================================================
// icache_valid_bits : 16 valid flops, one-hot set decode, indexed read select
// Rev 1.0 -- flush input present only with ICACHE_FLUSH_EN
// ============================================================================
`default_nettype none

module icache_valid_bits
  import icache_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
`ifdef ICACHE_FLUSH_EN
  input  logic   flush_i,
`endif
  input  logic   we_i,
  input  index_t widx_i,
  input  index_t ridx_i,
  output logic   valid_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [NUM_LINES-1:0] w_dec;

  assign w_dec = {{(NUM_LINES-1){1'b0}}, 1'b1} << widx_i;

  always_comb begin
    valid_d = valid_q;
`ifdef ICACHE_FLUSH_EN
    // Flush beats a same-edge fill: the acked line must end up invalid.
    if (flush_i) begin
      valid_d = '0;
    end else
`endif
    if (we_i) begin
      valid_d = valid_q | w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q[ridx_i];

endmodule

`default_nettype wire

// File: rtl/icache_dm16.sv
// ============================================================================
// icache_dm16 : direct-mapped 16 x 32-byte read-only instruction cache
// Rev 1.0 -- optional flush port with ICACHE_FLUSH_EN
// ============================================================================
`default_nettype none

module icache_dm16
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
`ifdef ICACHE_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                ren,
  input  logic [INDEX_W-1:0]  index,
  input  logic [2:0]          tag_14_12,
  input  logic [2:0]          tag_11_9,
  input  logic [LINE_W-1:0]   ic_fill_data,
  input  logic                ic_miss_ack,
  output logic [LINE_W-1:0]   r_data,
  output logic                ic_hit,
  output logic                ic_miss,
  output logic [ADDR_W-1:0]   ic_addr
);

  tag_t   w_phy_tag;
  logic   w_fill;
  logic   w_valid;
  logic   w_match;

  tag_t   tag_q  [NUM_LINES];
  line_t  data_q [NUM_LINES];

  assign w_phy_tag = {tag_14_12, tag_11_9};

`ifdef ICACHE_FLUSH_EN
  assign w_fill = ic_miss_ack & ~flush;
`else
  assign w_fill = ic_miss_ack;
`endif

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      tag_q[index]  <= w_phy_tag;
      data_q[index] <= ic_fill_data;
    end
  end

  icache_valid_bits u_valid_bits (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef ICACHE_FLUSH_EN
    .flush_i (flush),
`endif
    .we_i    (ic_miss_ack),
    .widx_i  (index),
    .ridx_i  (index),
    .valid_o (w_valid)
  );

  // Valid is ANDed first so an unfilled tag slot never leaks X into the hit.
  assign w_match = w_valid && (tag_q[index] == w_phy_tag);
  assign ic_hit  = ren & w_match;
  assign ic_miss = ren & ~w_match;
  assign r_data  = data_q[index];
  assign ic_addr = {w_phy_tag, index, {OFFSET_W{1'b0}}};

endmodule

`default_nettype wire

// File: tb/tb_icache_dm16.sv
// ============================================================================
// tb_icache_dm16 : table vectors, directed reset/flush sequences, random vs model
// Rev 1.0 -- flush checks compiled with ICACHE_FLUSH_EN
// ============================================================================
`default_nettype none

module tb_icache_dm16;

  logic         clk;
  logic         rst_n;
  logic         ren;
  logic [3:0]   index;
  logic [2:0]   tag_14_12;
  logic [2:0]   tag_11_9;
  logic [255:0] ic_fill_data;
  logic         ic_miss_ack;
  logic [255:0] r_data;
  logic         ic_hit;
  logic         ic_miss;
  logic [14:0]  ic_addr;
`ifdef ICACHE_FLUSH_EN
  logic         flush;
`endif

  icache_dm16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ICACHE_FLUSH_EN
    .flush        (flush),
`endif
    .ren          (ren),
    .index        (index),
    .tag_14_12    (tag_14_12),
    .tag_11_9     (tag_11_9),
    .ic_fill_data (ic_fill_data),
    .ic_miss_ack  (ic_miss_ack),
    .r_data       (r_data),
    .ic_hit       (ic_hit),
    .ic_miss      (ic_miss),
    .ic_addr      (ic_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the cache should hold, line by line.
  bit           mv [16];
  logic [5:0]   mt [16];
  logic [255:0] md [16];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit           ren;
    logic [3:0]   idx;
    logic [5:0]   tag;
    bit           ack;
    logic [255:0] data;
    bit           exp_hit;
    bit           exp_miss;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [3:0] i, input logic [5:0] t,
                       input bit a, input logic [255:0] d);
    ren          = r;
    index        = i;
    tag_14_12    = t[5:3];
    tag_11_9     = t[2:0];
    ic_miss_ack  = a;
    ic_fill_data = d;
  endtask

  task automatic check_model(input string nm);
    logic [5:0] t;
    bit         present;
    int         addr;
    #3;
    t       = {tag_14_12, tag_11_9};
    present = mv[index] && (mt[index] == t);
    addr    = t * 512 + index * 32;
    chk({nm, "_hit"},  {255'd0, ic_hit},  {255'd0, ren && present});
    chk({nm, "_miss"}, {255'd0, ic_miss}, {255'd0, ren && !present});
    chk({nm, "_addr"}, {241'd0, ic_addr}, 256'(addr));
    if (mv[index]) chk({nm, "_data"}, r_data, md[index]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
`ifdef ICACHE_FLUSH_EN
      if (flush) begin
        foreach (mv[k]) mv[k] = 1'b0;
      end else
`endif
      if (ic_miss_ack) begin
        mv[index] = 1'b1;
        mt[index] = {tag_14_12, tag_11_9};
        md[index] = ic_fill_data;
      end
    end
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] pa5, p3c, p11, pf0, p77;
    pa5 = {32{8'hA5}};
    p3c = {32{8'h3C}};
    p11 = {32{8'h11}};
    pf0 = {32{8'hF0}};
    p77 = {32{8'h77}};

    tbl[0]  = '{1'b1, 4'd3,  6'h15, 1'b0, 256'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'd3,  6'h15, 1'b1, pa5,    1'b0, 1'b1};
    tbl[2]  = '{1'b1, 4'd3,  6'h15, 1'b0, 256'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'd3,  6'h2A, 1'b0, 256'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'd3,  6'h2A, 1'b1, p3c,    1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'd3,  6'h15, 1'b0, 256'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 4'd3,  6'h2A, 1'b0, 256'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'd0,  6'h01, 1'b1, p11,    1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'd15, 6'h3F, 1'b1, pf0,    1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'd0,  6'h01, 1'b0, 256'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'd15, 6'h3F, 1'b0, 256'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'd7,  6'h00, 1'b0, 256'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'd0,  6'h01, 1'b0, 256'd0, 1'b0, 1'b0};

    foreach (mv[k]) mv[k] = 1'b0;

    rst_n = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    drive(1'b1, 4'd3, 6'h15, 1'b0, 256'd0);
    #3;
    chk("rst_hit",  {255'd0, ic_hit},  256'd0);
    chk("rst_miss", {255'd0, ic_miss}, 256'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Table vectors: hand-derived hit/miss plus model-derived addr/data.
    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].ren, tbl[v].idx, tbl[v].tag, tbl[v].ack, tbl[v].data);
      #3;
      chk($sformatf("tbl%0d_hit", v),  {255'd0, ic_hit},  {255'd0, tbl[v].exp_hit});
      chk($sformatf("tbl%0d_miss", v), {255'd0, ic_miss}, {255'd0, tbl[v].exp_miss});
      chk($sformatf("tbl%0d_addr", v), {241'd0, ic_addr}, 256'(tbl[v].tag * 512 + tbl[v].idx * 32));
      if (mv[tbl[v].idx]) chk($sformatf("tbl%0d_data", v), r_data, md[tbl[v].idx]);
      tick();
    end
    drive(1'b0, 4'd15, 6'h00, 1'b0, 256'd0);
    #3;
    chk("ren0_data15", r_data, pf0);
    tick();

    // Asynchronous reset mid-cycle drops the hit without a clock edge.
    drive(1'b1, 4'd3, 6'h2A, 1'b0, 256'd0);
    check_model("pre_async");
    #1;
    rst_n = 1'b0;
    foreach (mv[k]) mv[k] = 1'b0;
    #1;
    chk("async_hit",  {255'd0, ic_hit},  256'd0);
    chk("async_miss", {255'd0, ic_miss}, 256'd1);
    tick();
    drive(1'b1, 4'd3, 6'h2A, 1'b1, p77);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 4'd3, 6'h2A, 1'b0, 256'd0);
    check_model("post_rst_ack");
    tick();
    drive(1'b1, 4'd3, 6'h2A, 1'b1, p77);
    check_model("first_fill_ack");
    tick();
    drive(1'b1, 4'd3, 6'h2A, 1'b0, 256'd0);
    check_model("first_fill_hit");
    tick();

`ifdef ICACHE_FLUSH_EN
    drive(1'b1, 4'd5, 6'h07, 1'b1, p11);
    tick();
    drive(1'b1, 4'd5, 6'h07, 1'b0, 256'd0);
    check_model("fl_prefill");
    flush = 1'b1;
    drive(1'b1, 4'd5, 6'h07, 1'b1, p3c);
    tick();
    flush = 1'b0;
    drive(1'b1, 4'd5, 6'h07, 1'b0, 256'd0);
    #3;
    chk("flush_ack_miss", {255'd0, ic_miss}, 256'd1);
    chk("flush_ack_hit",  {255'd0, ic_hit},  256'd0);
    tick();
    drive(1'b1, 4'd3, 6'h2A, 1'b0, 256'd0);
    #3;
    chk("flush_other_hit", {255'd0, ic_hit}, 256'd0);
    tick();
`endif

    // Random traffic against the model; narrow tag range keeps hits frequent.
    for (int n = 0; n < 400; n++) begin
`ifdef ICACHE_FLUSH_EN
      flush = ($urandom_range(0, 15) == 0);
`endif
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            6'($urandom_range(0, 1) * 6'h2A + $urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, rand_line());
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
